// File: rtl/seg_scan_if.sv
// Display-side bundle of the 7-segment scan controller: the load port that
// feeds the display buffers and the multiplexed pins that drive the display.
interface seg_scan_if;
  logic [31:0] data_in;    // eight hex nibbles, nibble i -> digit i
  logic [7:0]  dp_in;      // decimal point per digit, 1 = lit
  logic [7:0]  en_in;      // digit enable per digit, 1 = shown
  logic        load;       // one-cycle strobe that captures the three inputs
  logic [7:0]  an;         // anode select, active low
  logic [6:0]  seg;        // segments {g,f,e,d,c,b,a}, active low
  logic        dp_n;       // decimal point, active low
  logic        frame_done; // one-cycle pulse at the end of the last slot

  // Whoever supplies display contents and watches the pins.
  modport master (
    output data_in, dp_in, en_in, load,
    input  an, seg, dp_n, frame_done
  );

  // The scan controller itself.
  modport slave (
    input  data_in, dp_in, en_in, load,
    output an, seg, dp_n, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Each digit owns a slot of CLK_DIV cycles whose first BLANK_CYC cycles keep
// every anode off. New contents wait in a pending buffer and are copied into
// the shadow buffer that is actually displayed only at the frame boundary,
// so a frame is never drawn from two different values.
module seg_scan_ctrl #(
  parameter int CLK_DIV   = 100000, // cycles per digit slot, >= 2
  parameter int BLANK_CYC = 1000,   // blank cycles at slot start, < CLK_DIV
  parameter int DIGITS    = 8       // scanned digits, 1..8
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);

  localparam int             CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [2:0]     IDX_LAST = 3'(DIGITS - 1);

  // Slot phase, derived from the slot counter rather than stored.
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
  } disp_buf_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          pend_q, pend_d;
  disp_buf_t     pend_buf_q, pend_buf_d;
  disp_buf_t     shadow_q, shadow_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_n_q, dp_n_d;
  logic          frame_done_q;

  logic      slot_end;
  logic      frame_end;
  logic [0:0] state;
  disp_buf_t in_buf;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);
  assign in_buf    = '{data: bus.data_in, dp: bus.dp_in, en: bus.en_in};

  // With no blank cycles the comparison would be constant, so drop it.
  if (BLANK_CYC == 0) begin : g_no_blank
    assign state = ST_SHOW;
  end else begin : g_blank
    assign state = (cnt_q < CW'(BLANK_CYC)) ? ST_BLANK : ST_SHOW;
  end

  // Active-low hex font for one digit.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Slot counter wraps every CLK_DIV cycles and advances the digit index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
  end

  // Pending/shadow buffering: loads park in pending, the frame boundary
  // publishes them, and a load on the boundary itself goes straight through.
  always_comb begin
    pend_d     = pend_q;
    pend_buf_d = pend_buf_q;
    shadow_d   = shadow_q;
    if (frame_end) begin
      if (bus.load)   shadow_d = in_buf;
      else if (pend_q) shadow_d = pend_buf_q;
      pend_d = 1'b0;
    end else if (bus.load) begin
      pend_buf_d = in_buf;
      pend_d     = 1'b1;
    end
  end

  // Pin values for the current slot; disabled digits still use their slot.
  always_comb begin
    an_d   = 8'hFF;
    seg_d  = 7'h7F;
    dp_n_d = 1'b1;
    if (state == ST_SHOW && shadow_q.en[idx_q]) begin
      an_d   = ~(8'h01 << idx_q);
      seg_d  = hex7(shadow_q.data[{idx_q, 2'b00} +: 4]);
      dp_n_d = ~shadow_q.dp[idx_q];
    end
  end

  // All state and the registered pins, cleared together by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      pend_q       <= 1'b0;
      // NOTE: the display buffers are reset on purpose so a dark display,
      // not stale garbage, is shown until the first frame boundary.
      pend_buf_q   <= '0;
      shadow_q     <= '0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_buf_q   <= pend_buf_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_end;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: three instances (basic, no-blank, three-digit)
// driven by the same inputs, each shadowed by a cycle-count reference model
// that derives the pins from elapsed cycles and per-frame buffer contents.
module tb_seg_scan_ctrl;

  localparam int          NI       = 3;
  localparam logic [16:0] RST_PINS = {8'hFF, 7'h7F, 1'b1, 1'b0};
  localparam logic [6:0]  HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic [31:0] data_r = '0;
  logic [7:0]  dp_r   = '0;
  logic [7:0]  en_r   = '0;
  logic        load_r = 1'b0;

  // Pins packed as {an[16:9], seg[8:2], dp_n[1], frame_done[0]}.
  logic [16:0] pins_w [NI];
  logic [16:0] exp_w  [NI];
  int          k_w    [NI];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Expected pins after the edge that processes cycle k of a free-running scan.
  function automatic logic [16:0] model_pins(input int k, input int cd, input int bc, input int dg,
                                             input logic [31:0] d, input logic [7:0] dp,
                                             input logic [7:0] en);
    int   slot = k % cd;
    int   dig  = (k / cd) % dg;
    logic fd   = ((k % (cd * dg)) == cd * dg - 1);
    if (slot < bc || !en[dig]) return {8'hFF, 7'h7F, 1'b1, fd};
    return {~(8'd1 << dig), HEX[d[dig*4 +: 4]], ~dp[dig], fd};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_cfg
    localparam int CD = 4;
    localparam int BC = (g == 1) ? 0 : 1;
    localparam int DG = (g == 2) ? 3 : 8;

    seg_scan_if b ();
    assign b.data_in = data_r;
    assign b.dp_in   = dp_r;
    assign b.en_in   = en_r;
    assign b.load    = load_r;

    seg_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYC(BC), .DIGITS(DG)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (b)
    );

    assign pins_w[g] = {b.an, b.seg, b.dp_n, b.frame_done};

    int          k;
    logic [31:0] sd, pd;
    logic [7:0]  sdp, pdp, sen, pen;
    logic        have;
    logic [16:0] ex;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        k <= 0; have <= 1'b0; ex <= RST_PINS;
        {sd, sdp, sen} <= '0; {pd, pdp, pen} <= '0;
      end else begin
        ex <= model_pins(k, CD, BC, DG, sd, sdp, sen);
        k  <= k + 1;
        if (k % (CD * DG) == CD * DG - 1) begin
          if (load_r)    {sd, sdp, sen} <= {data_r, dp_r, en_r};
          else if (have) {sd, sdp, sen} <= {pd, pdp, pen};
          have <= 1'b0;
        end else if (load_r) begin
          {pd, pdp, pen} <= {data_r, dp_r, en_r};
          have <= 1'b1;
        end
      end
    end

    assign exp_w[g] = ex;
    assign k_w[g]   = k;
  end

  task automatic test_reset();
    logic [7:0] first_an;
    rst_n = 1'b0; load_r = 1'b0; data_r = '0; dp_r = '0; en_r = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      n_chk++;
      if (pins_w[g] !== RST_PINS) begin n_fail++; $display("FAIL reset_hold[%0d]: got %h, expected %h", g, pins_w[g], RST_PINS); end
    end
    rst_n = 1'b1;
    data_r = 32'h76543210; en_r = 8'hFF; dp_r = 8'h00; load_r = 1'b1;
    first_an = 8'hFF;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk); load_r = 1'b0;
      for (int g = 0; g < NI; g++) begin
        n_chk++;
        if (pins_w[g] !== exp_w[g]) begin n_fail++; $display("FAIL reset_release[%0d] @%0t: got %h, expected %h", g, $time, pins_w[g], exp_w[g]); end
      end
      if (first_an == 8'hFF) first_an = pins_w[0][16:9];
    end
    n_chk++;
    if (first_an !== 8'hFE) begin n_fail++; $display("FAIL first_digit: got an=%h, expected FE", first_an); end
    // Reset in the middle of a lit slot clears the pins without a clock edge.
    for (int c = 0; c < 40 && pins_w[0][16:9] == 8'hFF; c++) @(negedge clk);
    n_chk++;
    if (pins_w[0][16:9] === 8'hFF) begin n_fail++; $display("FAIL show_timeout: got an=FF, expected a lit digit"); end
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      n_chk++;
      if (pins_w[g] !== RST_PINS) begin n_fail++; $display("FAIL reset_async[%0d]: got %h, expected %h", g, pins_w[g], RST_PINS); end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic_scan();
    logic [6:0] seg_seen [8];
    logic [7:0] an_exp;
    data_r = 32'h76543210; en_r = 8'hFF; dp_r = 8'h00; load_r = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); load_r = 1'b0;
      for (int g = 0; g < NI; g++) begin
        n_chk++;
        if (pins_w[g] !== exp_w[g]) begin n_fail++; $display("FAIL basic_wait[%0d] @%0t: got %h, expected %h", g, $time, pins_w[g], exp_w[g]); end
      end
      if (pins_w[0][0]) break;
    end
    n_chk++;
    if (pins_w[0][0] !== 1'b1) begin n_fail++; $display("FAIL basic_frame_timeout: got frame_done=0, expected 1"); end
    for (int i = 0; i < 8; i++) seg_seen[i] = 7'h7F;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        n_chk++;
        if (pins_w[g] !== exp_w[g]) begin n_fail++; $display("FAIL basic_model[%0d] @%0t: got %h, expected %h", g, $time, pins_w[g], exp_w[g]); end
      end
      an_exp = (c % 4 == 0) ? 8'hFF : ~(8'd1 << (c / 4));
      n_chk++;
      if (pins_w[0][16:9] !== an_exp || pins_w[0][0] !== (c == 31)) begin
        n_fail++; $display("FAIL basic_an c=%0d: got an=%h fd=%b, expected an=%h fd=%b", c, pins_w[0][16:9], pins_w[0][0], an_exp, c == 31);
      end
      if (pins_w[0][16:9] != 8'hFF) seg_seen[c / 4] = pins_w[0][8:2];
    end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (seg_seen[i] !== HEX[i]) begin n_fail++; $display("FAIL basic_seg digit %0d: got %h, expected %h", i, seg_seen[i], HEX[i]); end
    end
  endtask

  task automatic test_tear_free();
    int dig, shown;
    for (int c = 0; c < 40 && k_w[0] % 32 != 12; c++) @(negedge clk);
    data_r = 32'hFFFFFFFF; load_r = 1'b1;
    // Rest of the current frame: digits 3..7 keep the old value.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); load_r = 1'b0;
      for (int g = 0; g < NI; g++) begin
        n_chk++;
        if (pins_w[g] !== exp_w[g]) begin n_fail++; $display("FAIL tear_model[%0d] @%0t: got %h, expected %h", g, $time, pins_w[g], exp_w[g]); end
      end
      dig = ((k_w[0] - 1) % 32) / 4;
      if (pins_w[0][16:9] != 8'hFF) begin
        n_chk++;
        if (pins_w[0][8:2] !== HEX[dig]) begin n_fail++; $display("FAIL tear_old digit %0d: got %h, expected %h", dig, pins_w[0][8:2], HEX[dig]); end
      end
    end
    // Next frame: all F; two loads in this frame, the second must win.
    for (int f = 0; f < 2; f++) begin
      shown = 0;
      for (int c = 0; c < 32; c++) begin
        @(negedge clk); load_r = 1'b0;
        for (int g = 0; g < NI; g++) begin
          n_chk++;
          if (pins_w[g] !== exp_w[g]) begin n_fail++; $display("FAIL tear_next[%0d] @%0t: got %h, expected %h", g, $time, pins_w[g], exp_w[g]); end
        end
        if (pins_w[0][16:9] != 8'hFF) begin
          shown++;
          n_chk++;
          if (pins_w[0][8:2] !== (f == 0 ? 7'h0E : 7'h00)) begin
            n_fail++; $display("FAIL tear_new f=%0d: got %h, expected %h", f, pins_w[0][8:2], f == 0 ? 7'h0E : 7'h00);
          end
        end
        if (f == 0 && c == 4)  begin data_r = 32'h12345678; load_r = 1'b1; end
        if (f == 0 && c == 20) begin data_r = 32'h88888888; load_r = 1'b1; end
      end
      n_chk++;
      if (shown != 24) begin n_fail++; $display("FAIL tear_lit_cycles f=%0d: got %0d, expected 24", f, shown); end
    end
  endtask

  task automatic test_boundary_bypass();
    int   shown;
    logic first;
    for (int c = 0; c < 40 && k_w[0] % 32 != 31; c++) @(negedge clk);
    data_r = 32'hAAAAAAAA; load_r = 1'b1;
    @(negedge clk); load_r = 1'b0;
    shown = 0; first = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        n_chk++;
        if (pins_w[g] !== exp_w[g]) begin n_fail++; $display("FAIL bypass_model[%0d] @%0t: got %h, expected %h", g, $time, pins_w[g], exp_w[g]); end
      end
      if (pins_w[0][16:9] != 8'hFF) begin
        shown++;
        n_chk++;
        if (pins_w[0][8:2] !== 7'h08 || (first && pins_w[0][16:9] !== 8'hFE)) begin
          n_fail++; $display("FAIL bypass_seg c=%0d: got an=%h seg=%h, expected seg=08", c, pins_w[0][16:9], pins_w[0][8:2]);
        end
        first = 1'b0;
      end
    end
    n_chk++;
    if (shown != 48) begin n_fail++; $display("FAIL bypass_lit_cycles: got %0d, expected 48", shown); end
  endtask

  task automatic test_enable_dp();
    int n_fe, n_fb;
    data_r = $urandom; en_r = 8'b0000_0101; dp_r = 8'b0000_0100; load_r = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); load_r = 1'b0;
      if (pins_w[0][0]) break;
    end
    n_fe = 0; n_fb = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        n_chk++;
        if (pins_w[g] !== exp_w[g]) begin n_fail++; $display("FAIL en_model[%0d] @%0t: got %h, expected %h", g, $time, pins_w[g], exp_w[g]); end
      end
      if (pins_w[0][16:9] == 8'hFE) n_fe++;
      if (pins_w[0][16:9] == 8'hFB) n_fb++;
      n_chk++;
      if (!(pins_w[0][16:9] inside {8'hFF, 8'hFE, 8'hFB}) || (pins_w[0][1] == 1'b0) != (pins_w[0][16:9] == 8'hFB)) begin
        n_fail++; $display("FAIL en_dp c=%0d: got an=%h dp_n=%b, expected an in FF/FE/FB, dp_n=0 only with FB", c, pins_w[0][16:9], pins_w[0][1]);
      end
    end
    n_chk++;
    if (n_fe != 3 || n_fb != 3) begin n_fail++; $display("FAIL en_lit_cycles: got FE=%0d FB=%0d, expected 3 and 3", n_fe, n_fb); end
  endtask

  task automatic test_param_edges();
    int last_fd, prev_d, cur_d;
    data_r = $urandom; en_r = 8'hFF; dp_r = 8'($urandom); load_r = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); load_r = 1'b0;
      if (pins_w[0][0]) break;
    end
    last_fd = -1; prev_d = -1;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        n_chk++;
        if (pins_w[g] !== exp_w[g]) begin n_fail++; $display("FAIL edge_model[%0d] @%0t: got %h, expected %h", g, $time, pins_w[g], exp_w[g]); end
      end
      n_chk++;
      if (pins_w[1][16:9] === 8'hFF) begin n_fail++; $display("FAIL noblank_an c=%0d: got FF, expected a lit digit", c); end
      n_chk++;
      if (pins_w[2][16:12] !== 5'h1F) begin n_fail++; $display("FAIL dig3_high_an c=%0d: got an=%h, expected bits 7:3 high", c, pins_w[2][16:9]); end
      if (pins_w[2][0]) begin
        if (last_fd >= 0) begin
          n_chk++;
          if (c - last_fd != 12) begin n_fail++; $display("FAIL dig3_period: got %0d, expected 12", c - last_fd); end
        end
        last_fd = c;
      end
      cur_d = -1;
      for (int i = 0; i < 3; i++) if (pins_w[2][9+i] == 1'b0) cur_d = i;
      if (cur_d >= 0 && prev_d >= 0 && cur_d != prev_d) begin
        n_chk++;
        if (cur_d != (prev_d + 1) % 3) begin n_fail++; $display("FAIL dig3_wrap: got digit %0d after %0d, expected %0d", cur_d, prev_d, (prev_d + 1) % 3); end
      end
      if (cur_d >= 0) prev_d = cur_d;
    end
    n_chk++;
    if (last_fd < 0) begin n_fail++; $display("FAIL dig3_no_frame_done: got none, expected pulses"); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); load_r = 1'b0;
      for (int g = 0; g < NI; g++) begin
        n_chk++;
        if (pins_w[g] !== exp_w[g]) begin n_fail++; $display("FAIL random[%0d] @%0t: got %h, expected %h", g, $time, pins_w[g], exp_w[g]); end
      end
      if ($urandom_range(9, 0) == 0 || k_w[0] % 32 == 31 && $urandom_range(1, 0) == 1) begin
        data_r = $urandom; dp_r = 8'($urandom); en_r = 8'($urandom); load_r = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_boundary_bypass();
    test_enable_dp();
    test_param_edges();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
